// File: rtl/sigma_div_scheduler_if.sv
// Requester, divider and status signals of the sigma divider scheduler.
// slave = scheduler side, master = surrounding accumulators/divider/consumers.
interface sigma_div_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int DEND_BW = 42,
  parameter int DSOR_BW = 20
);
  logic [NUM_REQ-1:0]         i_req_valid;
  logic [NUM_REQ*DEND_BW-1:0] i_req_dend;
  logic [NUM_REQ*DSOR_BW-1:0] i_req_dsor;
  logic                       o_div_valid;
  logic [DEND_BW-1:0]         o_div_dend;
  logic [DSOR_BW-1:0]         o_div_dsor;
  logic                       i_div_valid;
  logic [DEND_BW-1:0]         i_div_quot;
  logic [NUM_REQ-1:0]         o_rsp_valid;
  logic [DEND_BW-1:0]         o_rsp_quot;
  logic                       o_busy;
  logic [NUM_REQ-1:0]         o_drop;
  logic                       o_timeout;

  modport slave (
    input  i_req_valid, i_req_dend, i_req_dsor, i_div_valid, i_div_quot,
    output o_div_valid, o_div_dend, o_div_dsor, o_rsp_valid, o_rsp_quot,
           o_busy, o_drop, o_timeout
  );

  modport master (
    output i_req_valid, i_req_dend, i_req_dsor, i_div_valid, i_div_quot,
    input  o_div_valid, o_div_dend, o_div_dsor, o_rsp_valid, o_rsp_quot,
           o_busy, o_drop, o_timeout
  );
endinterface

// File: rtl/sigma_div_scheduler.sv
// Round-robin sharing of one sequential unsigned divider among frame-end requesters.
// Optional WAIT watchdog enabled by defining SIGMA_DIV_SCHED_TIMEOUT_EN.
module sigma_div_scheduler #(
  parameter int NUM_REQ     = 2,
  parameter int DEND_BW     = 42,
  parameter int DSOR_BW     = 20,
  parameter int TIMEOUT_CYC = 64
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  sigma_div_scheduler_if.slave bus
);
  // state | meaning
  // IDLE  | pick next pending slot round-robin, latch its operands
  // ISSUE | one-cycle start pulse to the divider
  // WAIT  | divide in flight, wait for done (or watchdog)
  // RESP  | one-hot response pulse to the granted requester
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  localparam int GW = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [GW-1:0] LAST_RST = GW'(NUM_REQ - 1);

  state_t             state;
  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] clr_vec;
  logic [DEND_BW-1:0] slot_dend [NUM_REQ];
  logic [DSOR_BW-1:0] slot_dsor [NUM_REQ];
  logic [GW-1:0]      last_grant;
  logic [GW-1:0]      sel_g;
  logic [GW-1:0]      cand;
  logic               sel_found;

`ifdef SIGMA_DIV_SCHED_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // Loaded on ISSUE->WAIT so that expiry lands in RESP exactly TIMEOUT_CYC after ISSUE.
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 2);
  logic [TW-1:0] tmo_cnt;
`else
  assign bus.o_timeout = 1'b0;
`endif

  always_comb begin
    sel_found = 1'b0;
    sel_g     = last_grant;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((int'(last_grant) + i) % NUM_REQ);
      if (!sel_found && pend[cand]) begin
        sel_found = 1'b1;
        sel_g     = cand;
      end
    end
  end

  always_comb begin
    clr_vec = '0;
    if (state == ST_IDLE && sel_found)
      clr_vec = NUM_REQ'(1) << sel_g;
  end

  assign bus.o_busy = (state != ST_IDLE) || (|pend);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= ST_IDLE;
      pend            <= '0;
      last_grant      <= LAST_RST;
      for (int k = 0; k < NUM_REQ; k++) begin
        slot_dend[k] <= '0;
        slot_dsor[k] <= '0;
      end
      bus.o_div_valid <= 1'b0;
      bus.o_div_dend  <= '0;
      bus.o_div_dsor  <= '0;
      bus.o_rsp_valid <= '0;
      bus.o_rsp_quot  <= '0;
      bus.o_drop      <= '0;
`ifdef SIGMA_DIV_SCHED_TIMEOUT_EN
      tmo_cnt         <= '0;
      bus.o_timeout   <= 1'b0;
`endif
    end else begin
      bus.o_div_valid <= 1'b0;
      bus.o_rsp_valid <= '0;
      bus.o_drop      <= '0;
`ifdef SIGMA_DIV_SCHED_TIMEOUT_EN
      bus.o_timeout   <= 1'b0;
`endif
      // A new request outranks the grant-time clear of the same slot.
      for (int k = 0; k < NUM_REQ; k++) begin
        if (bus.i_req_valid[k]) begin
          slot_dend[k]  <= bus.i_req_dend[k*DEND_BW +: DEND_BW];
          slot_dsor[k]  <= bus.i_req_dsor[k*DSOR_BW +: DSOR_BW];
          pend[k]       <= 1'b1;
          bus.o_drop[k] <= pend[k] & ~clr_vec[k];
        end else if (clr_vec[k]) begin
          pend[k] <= 1'b0;
        end
      end

      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            bus.o_div_dend <= slot_dend[sel_g];
            bus.o_div_dsor <= slot_dsor[sel_g];
            last_grant     <= sel_g;
            if (slot_dsor[sel_g] == '0) begin
              bus.o_rsp_quot  <= '1;
              bus.o_rsp_valid <= NUM_REQ'(1) << sel_g;
              state           <= ST_RESP;
            end else begin
              bus.o_div_valid <= 1'b1;
              state           <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
`ifdef SIGMA_DIV_SCHED_TIMEOUT_EN
          tmo_cnt <= TMO_LOAD;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.i_div_valid) begin
            bus.o_rsp_quot  <= bus.i_div_quot;
            bus.o_rsp_valid <= NUM_REQ'(1) << last_grant;
            state           <= ST_RESP;
          end
`ifdef SIGMA_DIV_SCHED_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            bus.o_rsp_quot  <= '1;
            bus.o_rsp_valid <= NUM_REQ'(1) << last_grant;
            bus.o_timeout   <= 1'b1;
            state           <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sigma_div_scheduler.sv
// Scoreboard bench for sigma_div_scheduler: directed requests, a latency-44 divider
// model, and a negedge monitor popping expected responses.
module tb_sigma_div_scheduler;
  localparam int NR  = 2;
  localparam int DB  = 42;
  localparam int SB  = 20;
  localparam int TMO = 64;
  localparam int DIV_LAT = 44;
  localparam logic [DB-1:0] ALL1 = '1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sigma_div_scheduler_if #(.NUM_REQ(NR), .DEND_BW(DB), .DSOR_BW(SB)) bus();

  sigma_div_scheduler #(
    .NUM_REQ(NR), .DEND_BW(DB), .DSOR_BW(SB), .TIMEOUT_CYC(TMO)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    int            idx;
    logic [DB-1:0] quot;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_cur;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int div_cnt = 0;
  int rsp_cnt = 0;
  int tmo_cnt = 0;
  int drop_cnt [NR];
  int last_rsp_cyc = -1;
  int done_cyc = -1;
  logic last_rsp_tmo = 1'b0;
  bit div_respond = 1'b1;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic push(input int idx, input logic [DB-1:0] q);
    exp_t e;
    e.idx  = idx;
    e.quot = q;
    exp_q.push_back(e);
  endtask

  // Monitor / scoreboard
  initial for (int k = 0; k < NR; k++) drop_cnt[k] = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_div_valid) div_cnt++;
      for (int k = 0; k < NR; k++) if (bus.o_drop[k]) drop_cnt[k]++;
      if (bus.o_timeout) tmo_cnt++;
      if (bus.o_rsp_valid != '0) begin
        rsp_cnt++;
        last_rsp_cyc = cyc;
        last_rsp_tmo = bus.o_timeout;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got valid=%b quot=%0d, expected no response",
                   bus.o_rsp_valid, bus.o_rsp_quot);
        end else begin
          e_cur = exp_q.pop_front();
          chk("rsp_valid", 64'(bus.o_rsp_valid), 64'(NR'(1) << e_cur.idx));
          chk("rsp_quot", 64'(bus.o_rsp_quot), 64'(e_cur.quot));
        end
      end
    end
  end

  // Divider model: answers DIV_LAT cycles after the start pulse
  initial begin
    logic [DB-1:0] dd;
    logic [SB-1:0] ds;
    bus.i_div_valid = 1'b0;
    bus.i_div_quot  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_div_valid && div_respond) begin
        dd = bus.o_div_dend;
        ds = bus.o_div_dsor;
        repeat (DIV_LAT) @(negedge clk);
        bus.i_div_valid = 1'b1;
        bus.i_div_quot  = (ds == '0) ? ALL1 : dd / DB'(ds);
        done_cyc = cyc;
        @(negedge clk);
        bus.i_div_valid = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic req(input int k, input logic [DB-1:0] d, input logic [SB-1:0] s, output int t);
    bus.i_req_valid[k] = 1'b1;
    bus.i_req_dend[k*DB +: DB] = d;
    bus.i_req_dsor[k*SB +: SB] = s;
    t = cyc;
    @(negedge clk);
    bus.i_req_valid[k] = 1'b0;
  endtask

  task automatic req_both(input logic [DB-1:0] d0, input logic [SB-1:0] s0,
                          input logic [DB-1:0] d1, input logic [SB-1:0] s1);
    bus.i_req_valid = 2'b11;
    bus.i_req_dend  = {d1, d0};
    bus.i_req_dsor  = {s1, s0};
    @(negedge clk);
    bus.i_req_valid = '0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    repeat (3) @(negedge clk);
    while ((bus.o_busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s_idle: still busy=%0b with %0d responses outstanding after %0d cycles, expected idle",
               nm, bus.o_busy, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_req_valid = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int t, t2, d0, d1, r0, dv0;
    bus.i_req_valid = '0;
    bus.i_req_dend  = '0;
    bus.i_req_dsor  = '0;
    do_reset();

    // reset state
    chk("rst_div_valid", 64'(bus.o_div_valid), 0);
    chk("rst_rsp_valid", 64'(bus.o_rsp_valid), 0);
    chk("rst_rsp_quot", 64'(bus.o_rsp_quot), 0);
    chk("rst_busy", 64'(bus.o_busy), 0);
    chk("rst_drop", 64'(bus.o_drop), 0);
    chk("rst_timeout", 64'(bus.o_timeout), 0);

    // single request: 1000/10
    req(0, 1000, 10, t);
    push(0, 100);
    chk("single_no_early_issue", 64'(bus.o_div_valid), 0);
    chk("single_busy", 64'(bus.o_busy), 1);
    @(negedge clk);
    chk("single_issue_t2", 64'(bus.o_div_valid), 1);
    chk("single_div_dend", 64'(bus.o_div_dend), 1000);
    chk("single_div_dsor", 64'(bus.o_div_dsor), 10);
    @(negedge clk);
    chk("single_issue_one_cycle", 64'(bus.o_div_valid), 0);
    wait_idle(200, "single");
    chk("single_done_cyc", 64'(done_cyc), 64'(t + 2 + DIV_LAT));
    chk("single_rsp_lat", 64'(last_rsp_cyc), 64'(done_cyc + 1));

    // simultaneous requests after reset: 0 first, then 1
    do_reset();
    d0 = drop_cnt[0] + drop_cnt[1];
    req_both(600, 3, 900, 9);
    push(0, 200);
    push(1, 100);
    wait_idle(300, "simul");
    chk("simul_no_drop", 64'(drop_cnt[0] + drop_cnt[1]), 64'(d0));

    // fairness: five rounds of both requesting
    for (int r = 0; r < 5; r++) begin
      req_both(DB'((r + 1) * 70), 7, DB'((r + 1) * 3000), 1000);
      push(0, DB'(10 * (r + 1)));
      push(1, DB'(3 * (r + 1)));
      wait_idle(300, "fair");
    end

    // overwrite while requester 1 is in flight
    d0 = drop_cnt[0];
    d1 = drop_cnt[1];
    req(1, 700, 7, t);
    push(1, 100);
    @(negedge clk);
    chk("ovw_issue", 64'(bus.o_div_valid), 1);
    req(1, 880, 8, t2);
    req(0, 30, 3, t2);
    req(0, 50, 5, t2);
    chk("ovw_drop_pulse", 64'(bus.o_drop), 64'(2'b01));
    push(0, 10);
    push(1, 110);
    wait_idle(400, "ovw");
    chk("ovw_drop0_cnt", 64'(drop_cnt[0] - d0), 1);
    chk("ovw_drop1_cnt", 64'(drop_cnt[1] - d1), 0);

    // zero divisor
    dv0 = div_cnt;
    req(0, 123, 0, t);
    push(0, ALL1);
    wait_idle(50, "zdiv");
    chk("zdiv_rsp_cyc", 64'(last_rsp_cyc), 64'(t + 2));
    chk("zdiv_no_issue", 64'(div_cnt - dv0), 0);

    // new request to the slot being granted in the same cycle
    d0 = drop_cnt[0];
    req(0, 400, 4, t);
    req(0, 90, 9, t2);
    chk("samecyc_no_drop_pulse", 64'(bus.o_drop), 0);
    push(0, 100);
    push(0, 10);
    wait_idle(300, "samecyc");
    chk("samecyc_drop_cnt", 64'(drop_cnt[0] - d0), 0);

    // stray divider done while idle
    r0 = rsp_cnt;
    bus.i_div_valid = 1'b1;
    bus.i_div_quot  = 77;
    @(negedge clk);
    bus.i_div_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray_idle_no_rsp", 64'(rsp_cnt - r0), 0);
    chk("stray_idle_busy", 64'(bus.o_busy), 0);

    // silent divider
    div_respond = 1'b0;
    r0 = rsp_cnt;
    req(0, 77, 7, t);
`ifdef SIGMA_DIV_SCHED_TIMEOUT_EN
    push(0, ALL1);
    wait_idle(200, "tmo");
    chk("tmo_rsp_cyc", 64'(last_rsp_cyc), 64'(t + 2 + TMO));
    chk("tmo_flag_with_rsp", 64'(last_rsp_tmo), 1);
    bus.i_div_valid = 1'b1;
    bus.i_div_quot  = 11;
    @(negedge clk);
    bus.i_div_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("tmo_late_done_ignored", 64'(rsp_cnt - r0), 1);
    chk("tmo_pulse_cnt", 64'(tmo_cnt), 1);
`else
    repeat (100) @(negedge clk);
    chk("hold_busy", 64'(bus.o_busy), 1);
    chk("hold_no_rsp", 64'(rsp_cnt - r0), 0);
    push(0, 11);
    bus.i_div_valid = 1'b1;
    bus.i_div_quot  = 11;
    t2 = cyc;
    @(negedge clk);
    bus.i_div_valid = 1'b0;
    wait_idle(50, "hold");
    chk("hold_rsp_cyc", 64'(last_rsp_cyc), 64'(t2 + 1));
    chk("no_timeout_pulse", 64'(tmo_cnt), 0);
`endif
    div_respond = 1'b1;

    // reset mid-operation
    req(0, 500, 5, t);
    req(1, 10, 1, t2);
    repeat (3) @(negedge clk);
    do_reset();
    chk("abort_busy", 64'(bus.o_busy), 0);
    chk("abort_rsp_valid", 64'(bus.o_rsp_valid), 0);
    r0  = rsp_cnt;
    dv0 = div_cnt;
    repeat (60) @(negedge clk);
    chk("abort_no_rsp", 64'(rsp_cnt - r0), 0);
    chk("abort_no_issue", 64'(div_cnt - dv0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
